parity_frame_rx: RTL and testbench
==================================

Name: parity_frame_rx

Overview:
- Serial receiver that sits directly upstream of the 4-bit parity checker.
- Deserialises framed bits (start, DATA_W data LSB-first, parity, stop) into a parallel word {parity, data}.
- Flags parity and framing errors, and presents the word on a valid/ready output.
- Default width produces the 4-bit s vector consumed by the checker.

Parameters:
- DATA_W, 3: data bits per frame; output word is DATA_W+1 bits.
- PARITY_ODD, 0: 0 = even parity (XOR of data+parity == 0 is good); 1 = odd parity (XOR == 1 is good).

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ser_in  input  1  serial line; idles high.
- ser_en  input  1  bit strobe; ser_in is sampled only on cycles with ser_en=1.
- frame_out  output  DATA_W+1  {parity bit, data[DATA_W-1:0]}; feeds checker s.
- out_valid  output  1  frame_out holds an unconsumed frame.
- out_ready  input  1  downstream accepts; transfer occurs when out_valid & out_ready.
- par_err  output  1  parity mismatch for the frame in frame_out.
- frm_err  output  1  stop bit sampled as 0 for the frame in frame_out.
- overrun  output  1  one-cycle pulse: completed frame dropped.
- busy  output  1  FSM not in IDLE.

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE; bit counter=0; shift reg=0.
  - Outputs on reset: frame_out=0, out_valid=0, par_err=0, frm_err=0, overrun=0, busy=0.
  - Reset mid-frame discards the partial frame; reset while out_valid=1 drops the held word.
- FSM advances only on ser_en=1; with ser_en=0 all state holds.
  - IDLE: ser_in=0 -> DATA (start bit), counter=0; ser_in=1 -> stay.
  - DATA: shift ser_in into bit[counter]. Counter==DATA_W-1 -> PAR; else counter+1.
  - PAR: capture parity bit -> STOP.
  - STOP: sample stop bit -> IDLE; frame completes this cycle.
  - A start bit may be detected on the very next strobe after STOP (back-to-back frames).
- Parity computation: par_err = ^data ^ parity ^ PARITY_ODD.
- frm_err = ~stop_bit. The word is delivered even if par_err or frm_err is set.
- Output register load: on the STOP cycle, when (!out_valid | out_ready).
  - The next cycle shows frame_out, par_err, frm_err and out_valid=1 (latency 1 clk after the stop strobe).
- Simultaneous accept and load: the new frame replaces the old one; out_valid stays 1.
- Output register full (out_valid=1, out_ready=0) at STOP:
  - the new frame is dropped;
  - overrun pulses 1 cycle;
  - held word and flags are unchanged.
- Accept with no new frame: out_valid->0 next cycle. frame_out and flags hold their last value.
- frame_out, par_err and frm_err are stable while out_valid=1 and out_ready=0.
- busy=1 in DATA, PAR and STOP.

Optional Feature:
- Macro: PARITY_FRAME_RX_ERRCNT_EN.
- Defined: adds output err_cnt[7:0].
  - Saturating count (stops at 8'hFF) of completed frames with par_err|frm_err, including dropped frames.
  - Reset to 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package parity_pkg holds:
  - FSM state typedef (IDLE, DATA, PAR, STOP);
  - default DATA_W constant;
  - parity function par_of(data, odd) reused by the checker side.
- One sub-module: parity_out_reg, the single-entry valid/ready holding register with overrun detection.

Test Plan:
- Frame 1-case (DATA_W=3, even parity, out_ready=1): strobes 0,1,0,1,0,1 (start, data=3'b101, parity 0, stop) -> next clk frame_out=4'b0101, out_valid=1, par_err=0, frm_err=0.
- Parity error: same frame with parity 1 -> frame_out=4'b1101, par_err=1.
- Framing error: data 3'b001, parity 1, stop 0 -> frame_out=4'b1001, frm_err=1, par_err=0.
- Backpressure/overrun (out_ready=0):
  - two back-to-back frames, 3'b011 then 3'b110;
  - first frame held, frame_out=4'b0011;
  - overrun pulses once at second STOP;
  - raising out_ready -> out_valid=0 next clk.
- Reset mid-frame: rst_n=0 after 2 data strobes -> busy=0, out_valid=0 immediately; next full frame 3'b111 parity 1 -> frame_out=4'b1111, par_err=0.
- ser_en gaps: insert 3 idle clks between every strobe of frame 3'b010 -> identical result, frame_out=4'b1010; err_cnt (if enabled) unchanged.

Source files
------------

// File: rtl/parity_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : parity_pkg
//  Description : Shared types and parity helper for the parity frame receiver
//                and the downstream parity checker.
//  Revision    : 1.0 - initial release
// ============================================================================
package parity_pkg;

    localparam int DEF_DATA_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2,
        STOP = 2'd3
    } rx_state_t;

    // Returns 1 when the zero-extended word violates the selected parity sense.
    function automatic logic par_of(input logic [31:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage
`default_nettype wire

// File: rtl/parity_frame_rx_if.sv
`default_nettype none
// ============================================================================
//  Module      : parity_frame_rx_if
//  Description : Serial input and valid/ready word output of the receiver.
//                err_cnt exists only with PARITY_FRAME_RX_ERRCNT_EN defined.
//  Revision    : 1.0 - initial release
// ============================================================================
interface parity_frame_rx_if #(
    parameter int DATA_W = parity_pkg::DEF_DATA_W
);
    logic              ser_in;
    logic              ser_en;
    logic [DATA_W:0]   frame_out;
    logic              out_valid;
    logic              out_ready;
    logic              par_err;
    logic              frm_err;
    logic              overrun;
    logic              busy;
`ifdef PARITY_FRAME_RX_ERRCNT_EN
    logic [7:0]        err_cnt;
`endif

    modport master (
        output ser_in, ser_en, out_ready,
        input  frame_out, out_valid, par_err, frm_err, overrun, busy
`ifdef PARITY_FRAME_RX_ERRCNT_EN
        , input err_cnt
`endif
    );

    modport slave (
        input  ser_in, ser_en, out_ready,
        output frame_out, out_valid, par_err, frm_err, overrun, busy
`ifdef PARITY_FRAME_RX_ERRCNT_EN
        , output err_cnt
`endif
    );

endinterface
`default_nettype wire

// File: rtl/parity_out_reg.sv
`default_nettype none
// ============================================================================
//  Module      : parity_out_reg
//  Description : Single-entry valid/ready holding register; a load that finds
//                the entry full and not draining is dropped and flagged.
//  Revision    : 1.0 - initial release
// ============================================================================
module parity_out_reg #(
    parameter int WORD_W = 4
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              i_load,
    input  wire logic [WORD_W-1:0] i_word,
    input  wire logic              i_par_err,
    input  wire logic              i_frm_err,
    input  wire logic              i_ready,
    output logic      [WORD_W-1:0] o_word,
    output logic                   o_valid,
    output logic                   o_par_err,
    output logic                   o_frm_err,
    output logic                   o_overrun
);

    logic              r_valid;
    logic [WORD_W-1:0] r_word;
    logic              r_par_err;
    logic              r_frm_err;
    logic              r_overrun;
    logic              w_space;

    // Space exists when empty or when the held word leaves this same cycle.
    assign w_space = !r_valid || i_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_word    <= '0;
            r_par_err <= 1'b0;
            r_frm_err <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= i_load && !w_space;
            if (i_load && w_space) begin
                r_valid   <= 1'b1;
                r_word    <= i_word;
                r_par_err <= i_par_err;
                r_frm_err <= i_frm_err;
            end else if (r_valid && i_ready) begin
                r_valid   <= 1'b0;
            end
        end
    end

    assign o_word    = r_word;
    assign o_valid   = r_valid;
    assign o_par_err = r_par_err;
    assign o_frm_err = r_frm_err;
    assign o_overrun = r_overrun;

endmodule
`default_nettype wire

// File: rtl/parity_frame_rx.sv
`default_nettype none
// ============================================================================
//  Module      : parity_frame_rx
//  Description : Deserialises start/data/parity/stop frames into {parity,data}
//                with error flags. Optional macro PARITY_FRAME_RX_ERRCNT_EN
//                adds a saturating error-frame counter (err_cnt).
//  Revision    : 1.0 - initial release
// ============================================================================
module parity_frame_rx
    import parity_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter bit PARITY_ODD = 1'b0
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    parity_frame_rx_if.slave bus
);

    localparam int               CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(DATA_W - 1);

    rx_state_t         r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [DATA_W-1:0] r_shift, w_shift_nxt;
    logic              r_par, w_par_nxt;
    logic              w_done;
    logic              w_par_err;
    logic              w_frm_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_shift <= w_shift_nxt;
            r_par   <= w_par_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift_nxt = r_shift;
        w_par_nxt   = r_par;
        w_done      = 1'b0;
        if (bus.ser_en) begin
            case (r_state)
                IDLE: begin
                    if (!bus.ser_in) begin
                        w_state_nxt = DATA;
                        w_cnt_nxt   = '0;
                    end
                end
                DATA: begin
                    w_shift_nxt[r_cnt] = bus.ser_in;
                    if (r_cnt == c_LAST) begin
                        w_state_nxt = PAR;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                PAR: begin
                    w_par_nxt   = bus.ser_in;
                    w_state_nxt = STOP;
                end
                STOP: begin
                    w_done      = 1'b1;
                    w_state_nxt = IDLE;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Flags are evaluated on the STOP strobe, where the stop bit is ser_in itself.
    assign w_par_err = par_of(32'({r_par, r_shift}), PARITY_ODD);
    assign w_frm_err = !bus.ser_in;
    assign bus.busy  = (r_state != IDLE);

    parity_out_reg #(
        .WORD_W (DATA_W + 1)
    ) u_out_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_done),
        .i_word    ({r_par, r_shift}),
        .i_par_err (w_par_err),
        .i_frm_err (w_frm_err),
        .i_ready   (bus.out_ready),
        .o_word    (bus.frame_out),
        .o_valid   (bus.out_valid),
        .o_par_err (bus.par_err),
        .o_frm_err (bus.frm_err),
        .o_overrun (bus.overrun)
    );

`ifdef PARITY_FRAME_RX_ERRCNT_EN
    logic [7:0] r_err_cnt;

    // Counts every errored frame at completion, whether held or dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= 8'd0;
        end else if (w_done && (w_par_err || w_frm_err) && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign bus.err_cnt = r_err_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_parity_frame_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_parity_frame_rx
//  Description : Directed self-checking bench for parity_frame_rx (DATA_W=3,
//                even parity); err_cnt checked when PARITY_FRAME_RX_ERRCNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_parity_frame_rx;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    parity_frame_rx_if #(.DATA_W(3)) bus ();

    parity_frame_rx #(
        .DATA_W     (3),
        .PARITY_ODD (1'b0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge; presents one bit for the next rising edge.
    task automatic send_bit(input logic b, input int gaps);
        bus.ser_in = b;
        bus.ser_en = 1'b1;
        @(negedge clk);
        if (gaps > 0) begin
            bus.ser_en = 1'b0;
            bus.ser_in = 1'b1;
            repeat (gaps) @(negedge clk);
        end
    endtask

    // Returns at the negedge right after the stop strobe edge, line idle.
    task automatic send_frame(input logic [2:0] d, input logic p, input logic s, input int gaps);
        send_bit(1'b0, gaps);
        for (int i = 0; i < 3; i++) send_bit(d[i], gaps);
        send_bit(p, gaps);
        send_bit(s, 0);
        bus.ser_en = 1'b0;
        bus.ser_in = 1'b1;
    endtask

    task automatic test_reset();
        bus.ser_in    = 1'b1;
        bus.ser_en    = 1'b0;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.frame_out !== 4'b0000) begin errors++; $display("FAIL reset_frame_out got %b exp 0000", bus.frame_out); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
        checks++; if (bus.par_err !== 1'b0) begin errors++; $display("FAIL reset_par_err got %b exp 0", bus.par_err); end
        checks++; if (bus.frm_err !== 1'b0) begin errors++; $display("FAIL reset_frm_err got %b exp 0", bus.frm_err); end
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", bus.overrun); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
`ifdef PARITY_FRAME_RX_ERRCNT_EN
        checks++; if (bus.err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err_cnt got %0d exp 0", bus.err_cnt); end
`endif
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_good_frame();
        bus.out_ready = 1'b1;
        send_bit(1'b0, 0);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL good_busy got %b exp 1", bus.busy); end
        send_bit(1'b1, 0); send_bit(1'b0, 0); send_bit(1'b1, 0); send_bit(1'b0, 0); send_bit(1'b1, 0);
        bus.ser_en = 1'b0;
        checks++; if (bus.frame_out !== 4'b0101) begin errors++; $display("FAIL good_frame_out got %b exp 0101", bus.frame_out); end
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL good_out_valid got %b exp 1", bus.out_valid); end
        checks++; if (bus.par_err !== 1'b0) begin errors++; $display("FAIL good_par_err got %b exp 0", bus.par_err); end
        checks++; if (bus.frm_err !== 1'b0) begin errors++; $display("FAIL good_frm_err got %b exp 0", bus.frm_err); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL good_idle_busy got %b exp 0", bus.busy); end
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL good_accept_valid got %b exp 0", bus.out_valid); end
        checks++; if (bus.frame_out !== 4'b0101) begin errors++; $display("FAIL good_hold_after_accept got %b exp 0101", bus.frame_out); end
    endtask

    task automatic test_parity_error();
        send_frame(3'b101, 1'b1, 1'b1, 0);
        checks++; if (bus.frame_out !== 4'b1101) begin errors++; $display("FAIL parerr_frame_out got %b exp 1101", bus.frame_out); end
        checks++; if (bus.par_err !== 1'b1) begin errors++; $display("FAIL parerr_par_err got %b exp 1", bus.par_err); end
        checks++; if (bus.frm_err !== 1'b0) begin errors++; $display("FAIL parerr_frm_err got %b exp 0", bus.frm_err); end
`ifdef PARITY_FRAME_RX_ERRCNT_EN
        checks++; if (bus.err_cnt !== 8'd1) begin errors++; $display("FAIL parerr_err_cnt got %0d exp 1", bus.err_cnt); end
`endif
        @(negedge clk);
    endtask

    task automatic test_framing_error();
        send_frame(3'b001, 1'b1, 1'b0, 0);
        checks++; if (bus.frame_out !== 4'b1001) begin errors++; $display("FAIL frmerr_frame_out got %b exp 1001", bus.frame_out); end
        checks++; if (bus.frm_err !== 1'b1) begin errors++; $display("FAIL frmerr_frm_err got %b exp 1", bus.frm_err); end
        checks++; if (bus.par_err !== 1'b0) begin errors++; $display("FAIL frmerr_par_err got %b exp 0", bus.par_err); end
`ifdef PARITY_FRAME_RX_ERRCNT_EN
        checks++; if (bus.err_cnt !== 8'd2) begin errors++; $display("FAIL frmerr_err_cnt got %0d exp 2", bus.err_cnt); end
`endif
        @(negedge clk);
    endtask

    task automatic test_back_to_back_overrun();
        bus.out_ready = 1'b0;
        send_frame(3'b011, 1'b0, 1'b1, 0);
        checks++; if (bus.frame_out !== 4'b0011) begin errors++; $display("FAIL ovr_first_frame_out got %b exp 0011", bus.frame_out); end
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL ovr_first_valid got %b exp 1", bus.out_valid); end
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL ovr_first_overrun got %b exp 0", bus.overrun); end
        send_frame(3'b110, 1'b0, 1'b1, 0);
        checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL ovr_pulse got %b exp 1", bus.overrun); end
        checks++; if (bus.frame_out !== 4'b0011) begin errors++; $display("FAIL ovr_held_frame got %b exp 0011", bus.frame_out); end
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL ovr_held_valid got %b exp 1", bus.out_valid); end
        @(negedge clk);
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL ovr_pulse_end got %b exp 0", bus.overrun); end
        bus.out_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL ovr_drain_valid got %b exp 0", bus.out_valid); end
        checks++; if (bus.frame_out !== 4'b0011) begin errors++; $display("FAIL ovr_drain_frame got %b exp 0011", bus.frame_out); end
`ifdef PARITY_FRAME_RX_ERRCNT_EN
        checks++; if (bus.err_cnt !== 8'd2) begin errors++; $display("FAIL ovr_err_cnt got %0d exp 2", bus.err_cnt); end
`endif
    endtask

    task automatic test_reset_mid_frame();
        bus.out_ready = 1'b0;
        send_frame(3'b100, 1'b1, 1'b1, 0);
        send_bit(1'b0, 0); send_bit(1'b1, 0); send_bit(1'b1, 0);
        bus.ser_en = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", bus.busy); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b exp 0", bus.out_valid); end
        checks++; if (bus.frame_out !== 4'b0000) begin errors++; $display("FAIL midrst_frame got %b exp 0000", bus.frame_out); end
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        send_frame(3'b111, 1'b1, 1'b1, 0);
        checks++; if (bus.frame_out !== 4'b1111) begin errors++; $display("FAIL midrst_next_frame got %b exp 1111", bus.frame_out); end
        checks++; if (bus.par_err !== 1'b0) begin errors++; $display("FAIL midrst_next_par_err got %b exp 0", bus.par_err); end
`ifdef PARITY_FRAME_RX_ERRCNT_EN
        checks++; if (bus.err_cnt !== 8'd0) begin errors++; $display("FAIL midrst_err_cnt got %0d exp 0", bus.err_cnt); end
`endif
        @(negedge clk);
    endtask

    task automatic test_ser_en_gaps();
        bus.out_ready = 1'b1;
        send_frame(3'b010, 1'b1, 1'b1, 3);
        checks++; if (bus.frame_out !== 4'b1010) begin errors++; $display("FAIL gaps_frame_out got %b exp 1010", bus.frame_out); end
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL gaps_valid got %b exp 1", bus.out_valid); end
        checks++; if (bus.par_err !== 1'b0) begin errors++; $display("FAIL gaps_par_err got %b exp 0", bus.par_err); end
        checks++; if (bus.frm_err !== 1'b0) begin errors++; $display("FAIL gaps_frm_err got %b exp 0", bus.frm_err); end
`ifdef PARITY_FRAME_RX_ERRCNT_EN
        checks++; if (bus.err_cnt !== 8'd0) begin errors++; $display("FAIL gaps_err_cnt got %0d exp 0", bus.err_cnt); end
`endif
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        @(negedge clk);
        test_reset();
        test_good_frame();
        test_parity_error();
        test_framing_error();
        test_back_to_back_overrun();
        test_reset_mid_frame();
        test_ser_en_gaps();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
